// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame length and the
// helper that builds the two upper frame slots (data bit 7 / parity / stop).
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } uart_state_e;

  localparam int FRAME_LEN = 11;

  // Returns {b10, b9}. Parity covers the active data bits only, and ohel
  // selects odd (1) or even (0) sense. The receive side reuses this for checking.
  function automatic logic [1:0] frame_hi_bits(input logic [7:0] d,
                                               input logic       bit8,
                                               input logic       pen,
                                               input logic       ohel);
    logic par;
    par = (bit8 ? (^d) : (^d[6:0])) ^ ohel;
    case ({bit8, pen})
      2'b00:   return 2'b11;
      2'b01:   return {1'b1, par};
      2'b10:   return {1'b1, d[7]};
      default: return {par, d[7]};
    endcase
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-time counter: counts clocks while enabled and emits a one-cycle btu
// when the count reaches limit-1, then restarts from zero.
module uart_bit_timer #(
  parameter int BAUD_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic [BAUD_W-1:0] limit,
  output logic              btu
);

  logic [BAUD_W-1:0] cnt_q;
  logic [BAUD_W-1:0] cnt_d;

  // limit is never zero here; the caller maps 0 to 1 before latching
  assign btu = en && (cnt_q == (limit - BAUD_W'(1)));

  // Next count: wrap to zero on btu so the counter never overflows
  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (en)  cnt_d = btu ? '0 : (cnt_q + BAUD_W'(1));
  end

  // Counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: latches a byte and frame controls on load, builds an
// 11-slot frame (idle, start, data, b9, b10) and shifts it out LSB-first.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int BAUD_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [7:0]        out_port,
  input  logic              bit8,
  input  logic              pen,
  input  logic              ohel,
  input  logic [BAUD_W-1:0] baud_val,
  output logic              tx,
  output logic              txrdy,
  output logic              tx_done
);

  uart_state_e          state_q;
  logic [FRAME_LEN-1:0] sr_q;
  logic [3:0]           slot_q;
  logic                 txrdy_q;
  logic                 tx_done_q;

  logic [7:0]           data_q;
  logic                 bit8_q;
  logic                 pen_q;
  logic                 ohel_q;
  logic [BAUD_W-1:0]    baud_q;
  logic [BAUD_W-1:0]    baud_d;

  logic                 accept;
  logic                 btu;
  logic [1:0]           hi_bits;

  assign accept  = (state_q == ST_IDLE) && load;
  assign baud_d  = (baud_val == '0) ? BAUD_W'(1) : baud_val;
  assign hi_bits = frame_hi_bits(data_q, bit8_q, pen_q, ohel_q);

  assign tx      = sr_q[0];
  assign txrdy   = txrdy_q;
  assign tx_done = tx_done_q;

  uart_bit_timer #(
    .BAUD_W (BAUD_W)
  ) u_bit_timer (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == ST_SHIFT),
    .clr   (state_q == ST_LOAD),
    .limit (baud_q),
    .btu   (btu)
  );

  // Capture the byte and frame controls so later input changes cannot disturb the frame
  always_ff @(posedge clk) begin
    if (accept) begin
      data_q <= out_port;
      bit8_q <= bit8;
      pen_q  <= pen;
      ohel_q <= ohel;
      baud_q <= baud_d;
    end
  end

  // Frame sequencer: IDLE -> LOAD (build frame) -> SHIFT (11 slots) -> IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      sr_q      <= '1;
      slot_q    <= '0;
      txrdy_q   <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            txrdy_q <= 1'b0;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // slot 0 is an idle high so back-to-back frames keep a gap before the start bit
          sr_q    <= {hi_bits, data_q[6:0], 1'b0, 1'b1};
          slot_q  <= '0;
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (btu) begin
            sr_q   <= {1'b1, sr_q[FRAME_LEN-1:1]};
            slot_q <= slot_q + 4'd1;
            if (slot_q == 4'(FRAME_LEN - 1)) begin
              state_q   <= ST_IDLE;
              txrdy_q   <= 1'b1;
              tx_done_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: a frame-level reference model,
// a per-cycle compare process, directed frames with literal slot patterns,
// and a randomized phase.
module tb_uart_tx_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [7:0]  out_port;
  logic        bit8;
  logic        pen;
  logic        ohel;
  logic [19:0] baud_val;
  logic        tx;
  logic        txrdy;
  logic        tx_done;

  int checks = 0;
  int errors = 0;

  uart_tx_engine #(.BAUD_W(20)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .out_port (out_port),
    .bit8     (bit8),
    .pen      (pen),
    .ohel     (ohel),
    .baud_val (baud_val),
    .tx       (tx),
    .txrdy    (txrdy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
    end
  endtask

  // Frame as a list of slot values: idle, start, n data bits, optional parity, stop fill
  function automatic logic [10:0] build_frame(input logic [7:0] d, input logic b8,
                                              input logic p, input logic o);
    logic [10:0] f;
    int n;
    logic par;
    f = '1;
    f[1] = 1'b0;
    n = b8 ? 8 : 7;
    par = o;
    for (int i = 0; i < n; i++) begin
      f[2 + i] = d[i];
      par = par ^ d[i];
    end
    if (p) f[2 + n] = par;
    return f;
  endfunction

  // Reference model: cycle count since acceptance determines the slot on the line
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_t = 0;
  int          m_baud = 1;
  logic [10:0] m_frame = '1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_t    <= 0;
    end else if (!m_busy) begin
      m_done <= 1'b0;
      if (load) begin
        m_busy  <= 1'b1;
        m_t     <= 0;
        m_frame <= build_frame(out_port, bit8, pen, ohel);
        m_baud  <= (baud_val == 0) ? 1 : int'(baud_val);
      end
    end else begin
      m_t <= m_t + 1;
      if (m_t + 1 == 1 + 11 * m_baud) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end else begin
        m_done <= 1'b0;
      end
    end
  end

  // Compare DUT outputs to the model on every falling edge
  always @(negedge clk) begin
    int exp_tx;
    if (!m_busy || m_t == 0) exp_tx = 1;
    else                     exp_tx = int'(m_frame[(m_t - 1) / m_baud]);
    check("cyc_tx", int'(tx), exp_tx);
    check("cyc_txrdy", int'(txrdy), int'(!m_busy));
    check("cyc_tx_done", int'(tx_done), int'(m_done));
  end

  task automatic run_frame(input logic [7:0] d, input logic b8, input logic p,
                           input logic o, input logic [19:0] bv,
                           input logic [10:0] exp_slots, input bit inject,
                           input bit chained);
    int eff;
    int n;
    eff = (bv == 0) ? 1 : int'(bv);
    out_port = d; bit8 = b8; pen = p; ohel = o; baud_val = bv;
    if (chained) check("b2b_txrdy", int'(txrdy), 1);
    n = 0;
    while (!txrdy && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!txrdy) begin
      check("txrdy_timeout", 0, 1);
      return;
    end
    load = 1'b1;
    @(posedge clk); #1;               // E0
    load = 1'b0;
    check("e0_txrdy", int'(txrdy), 0);
    @(posedge clk); #1;               // E1
    for (int s = 0; s < 11; s++) begin
      if (s > 0) begin
        repeat (eff) @(posedge clk);
        #1;
      end
      check($sformatf("slot%0d", s), int'(tx), int'(exp_slots[s]));
      if (inject && s == 3) begin
        load = 1'b1; out_port = 8'hFF; bit8 = ~bit8; pen = ~pen; ohel = ~ohel;
        baud_val = 20'd9;
      end
      if (inject && s == 4) load = 1'b0;
    end
    repeat (eff) @(posedge clk);
    #1;                               // E1 + 11*baud
    check("end_tx_done", int'(tx_done), 1);
    check("end_txrdy", int'(txrdy), 1);
    check("end_tx", int'(tx), 1);
  endtask

  logic [10:0] pin;

  initial begin
    reset = 1'b0; load = 1'b0; out_port = 8'h00;
    bit8 = 1'b0; pen = 1'b0; ohel = 1'b0; baud_val = 20'd0;

    // Pin the model's frame builder to hand-derived slot patterns
    pin = build_frame(8'h5C, 1'b1, 1'b1, 1'b0);
    check("model_5c_even", int'(pin), int'(11'b00101110001));
    pin = build_frame(8'hC1, 1'b0, 1'b1, 1'b0);
    check("model_c1_7p", int'(pin), int'(11'b10100000101));
    pin = build_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    check("model_a5_8n", int'(pin), int'(11'b11010010101));

    #12;
    check("rst_tx", int'(tx), 1);
    check("rst_txrdy", int'(txrdy), 1);
    check("rst_tx_done", int'(tx_done), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_frame(8'h5C, 1'b1, 1'b1, 1'b0, 20'd4, 11'b00101110001, 1'b0, 1'b0);
    run_frame(8'h5C, 1'b1, 1'b1, 1'b1, 20'd4, 11'b10101110001, 1'b0, 1'b0);
    run_frame(8'hC1, 1'b0, 1'b1, 1'b0, 20'd4, 11'b10100000101, 1'b0, 1'b0);
    run_frame(8'hC1, 1'b0, 1'b0, 1'b0, 20'd4, 11'b11100000101, 1'b1, 1'b0);
    run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 20'd3, 11'b11010010101, 1'b0, 1'b1);
    run_frame(8'h3C, 1'b1, 1'b1, 1'b1, 20'd0, 11'b10011110001, 1'b0, 1'b0);

    // Mid-frame asynchronous reset during a low slot
    out_port = 8'h5C; bit8 = 1'b1; pen = 1'b1; ohel = 1'b0; baud_val = 20'd4;
    @(posedge clk); #1;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    @(posedge clk);                   // E1
    repeat (12) @(posedge clk);
    #1;
    check("pre_rst_tx", int'(tx), 0);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_tx", int'(tx), 1);
    check("async_rst_txrdy", int'(txrdy), 1);
    check("async_rst_tx_done", int'(tx_done), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    run_frame(8'h5C, 1'b1, 1'b1, 1'b0, 20'd4, 11'b00101110001, 1'b0, 1'b0);

    // Randomized traffic with inputs changing every cycle
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      load     = ($urandom_range(0, 3) == 0);
      out_port = 8'($urandom);
      bit8     = 1'($urandom);
      pen      = 1'($urandom);
      ohel     = 1'($urandom);
      baud_val = 20'($urandom_range(0, 6));
    end
    load = 1'b0;
    for (int c = 0; c < 200 && !txrdy; c++) begin
      @(posedge clk); #1;
    end
    check("final_txrdy", int'(txrdy), 1);
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
